// File: rtl/cq_array_if.sv
// Bus bundle for cq_array: enqueue port, wakeup ports, dequeue port and occupancy.
//
// Handshake: a transfer happens on a rising clock edge where both valid and
// ready are 1. The ready side never looks at valid to form ready, and the
// valid side holds its payload stable while valid=1 and ready=0.
interface cq_array_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int COND_WIDTH  = 2,
    parameter int INDEX_WIDTH = 4,
    parameter int DEPTH       = 8,
    parameter int NUM_WAKEUP  = 2
);
    logic                              enq_valid;
    logic                              enq_ready;
    logic [DATA_WIDTH-1:0]             enq_data;
    logic [COND_WIDTH-1:0]             enq_cond;
    logic [INDEX_WIDTH-1:0]            enq_index;
    logic [NUM_WAKEUP-1:0]             wk_valid;
    logic [NUM_WAKEUP*INDEX_WIDTH-1:0] wk_index;
    logic [NUM_WAKEUP*COND_WIDTH-1:0]  wk_mask;
    logic                              deq_valid;
    logic                              deq_ready;
    logic [DATA_WIDTH-1:0]             deq_data;
    logic [INDEX_WIDTH-1:0]            deq_index;
    logic [$clog2(DEPTH+1)-1:0]        count;

    modport master (
        output enq_valid, enq_data, enq_cond, enq_index,
        output wk_valid, wk_index, wk_mask,
        output deq_ready,
        input  enq_ready, deq_valid, deq_data, deq_index, count
    );

    modport slave (
        input  enq_valid, enq_data, enq_cond, enq_index,
        input  wk_valid, wk_index, wk_mask,
        input  deq_ready,
        output enq_ready, deq_valid, deq_data, deq_index, count
    );
endinterface

// File: rtl/cq_array.sv
// DEPTH-deep condition queue. Entries wait until every condition bit has been
// set by tag-matched wakeups, then the oldest ready entry is offered on the
// dequeue port. Relative age is kept in an age matrix (older_q[i][j]=1 means
// entry i was enqueued before entry j).
module cq_array #(
    parameter int DATA_WIDTH  = 32,
    parameter int COND_WIDTH  = 2,
    parameter int INDEX_WIDTH = 4,
    parameter int DEPTH       = 8,
    parameter int NUM_WAKEUP  = 2
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     flush,
    cq_array_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]       valid_q;
    logic [DATA_WIDTH-1:0]  data_q  [DEPTH];
    logic [INDEX_WIDTH-1:0] tag_q   [DEPTH];
    logic [COND_WIDTH-1:0]  cond_q  [DEPTH];
    logic [DEPTH-1:0]       older_q [DEPTH];

    logic [DEPTH-1:0]       ready_vec;
    logic [DEPTH-1:0]       blocked_vec;
    logic [DEPTH-1:0]       sel_vec;
    logic [DEPTH-1:0]       alloc_vec;
    logic                   alloc_found;
    logic [CNT_W-1:0]       count_w;
    logic [COND_WIDTH-1:0]  wk_hit [DEPTH];
    logic [COND_WIDTH-1:0]  enq_bypass;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [INDEX_WIDTH-1:0] sel_tag;
    logic                   enq_fire;
    logic                   deq_fire;

    // Ready entries and the single oldest one among them (one-hot select).
    always_comb begin
        ready_vec   = '0;
        blocked_vec = '0;
        sel_vec     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = valid_q[i] && (&cond_q[i]);
        end
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready_vec[j] && older_q[j][i]) begin
                    blocked_vec[i] = 1'b1;
                end
            end
            sel_vec[i] = ready_vec[i] && !blocked_vec[i];
        end
    end

    // Lowest-numbered free slot, based on pre-edge validity only.
    always_comb begin
        alloc_vec   = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !alloc_found) begin
                alloc_vec[i] = 1'b1;
                alloc_found  = 1'b1;
            end
        end
    end

    // Occupancy is the population count of the valid bits.
    always_comb begin
        count_w = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_w = count_w + CNT_W'(valid_q[i]);
        end
    end

    // Wakeup masks per stored entry and the bypass mask for the incoming entry.
    always_comb begin
        enq_bypass = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wk_hit[i] = '0;
        end
        for (int k = 0; k < NUM_WAKEUP; k++) begin
            if (bus.wk_valid[k]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (bus.wk_index[k*INDEX_WIDTH +: INDEX_WIDTH] == tag_q[i]) begin
                        wk_hit[i] = wk_hit[i] | bus.wk_mask[k*COND_WIDTH +: COND_WIDTH];
                    end
                end
                if (bus.wk_index[k*INDEX_WIDTH +: INDEX_WIDTH] == bus.enq_index) begin
                    enq_bypass = enq_bypass | bus.wk_mask[k*COND_WIDTH +: COND_WIDTH];
                end
            end
        end
    end

    // Payload and tag of the selected entry (OR of one-hot masked fields).
    always_comb begin
        sel_data = '0;
        sel_tag  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_vec[i]) begin
                sel_data = sel_data | data_q[i];
                sel_tag  = sel_tag  | tag_q[i];
            end
        end
    end

    assign bus.enq_ready = (count_w < CNT_W'(DEPTH)) && !flush && !reset;
    assign bus.deq_valid = (|ready_vec) && !flush;
    assign bus.deq_data  = bus.deq_valid ? sel_data : '0;
    assign bus.deq_index = bus.deq_valid ? sel_tag  : '0;
    assign bus.count     = count_w;

    assign enq_fire = bus.enq_valid && bus.enq_ready;
    assign deq_fire = bus.deq_valid && bus.deq_ready;

    // Entry storage and age matrix: reset/flush clear, otherwise dequeue, enqueue, wakeup.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= '0;
                tag_q[i]   <= '0;
                cond_q[i]  <= '0;
                older_q[i] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= '0;
                tag_q[i]   <= '0;
                cond_q[i]  <= '0;
                older_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (deq_fire && sel_vec[i]) begin
                    // Dequeued entry: wakeups landing on it this cycle are dropped.
                    valid_q[i]  <= 1'b0;
                    data_q[i]   <= '0;
                    tag_q[i]    <= '0;
                    cond_q[i]   <= '0;
                    older_q[i]  <= '0;
                end else if (enq_fire && alloc_vec[i]) begin
                    valid_q[i]  <= 1'b1;
                    data_q[i]   <= bus.enq_data;
                    tag_q[i]    <= bus.enq_index;
                    cond_q[i]   <= bus.enq_cond | enq_bypass;
                    older_q[i]  <= '0;
                end else if (valid_q[i]) begin
                    cond_q[i]   <= cond_q[i] | wk_hit[i];
                end
            end
            // Every other slot becomes older than the newly written one.
            for (int s = 0; s < DEPTH; s++) begin
                if (enq_fire && alloc_vec[s]) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        if (j != s) begin
                            older_q[j][s] <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: doc/cq_array.md
Name: cq_array

Overview:
- Multi-entry condition queue for the backend issue stage; generalises the single condition-queue entry into a DEPTH-deep array.
- Each entry holds a payload, a per-entry tag and COND_WIDTH condition bits.
- NUM_WAKEUP wakeup ports set condition bits by tag match; an entry is ready once valid and all its condition bits are set.
- The oldest ready entry is offered on a valid/ready dequeue port; age order is tracked by an age matrix.

Parameters:
- DATA_WIDTH, 32, payload width.
- COND_WIDTH, 2, condition bits per entry.
- INDEX_WIDTH, 4, tag width used for wakeup matching.
- DEPTH, 8, number of entries (>=2).
- NUM_WAKEUP, 2, number of wakeup ports.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  invalidate all entries.
- enq_valid  in  1  enqueue request.
- enq_ready  out  1  space available.
- enq_data  in  DATA_WIDTH  payload.
- enq_cond  in  COND_WIDTH  initial condition bits.
- enq_index  in  INDEX_WIDTH  entry tag.
- wk_valid  in  NUM_WAKEUP  per-port wakeup strobe.
- wk_index  in  NUM_WAKEUP*INDEX_WIDTH  tag to match; port k occupies bits [k*INDEX_WIDTH +: INDEX_WIDTH].
- wk_mask  in  NUM_WAKEUP*COND_WIDTH  bits to OR into matching entries' conditions.
- deq_valid  out  1  a ready entry is offered.
- deq_ready  in  1  consumer accepts.
- deq_data  out  DATA_WIDTH  payload of selected entry.
- deq_index  out  INDEX_WIDTH  tag of selected entry.
- count  out  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Reset (async, reset=1):
  - All entries invalid; payload, tag and condition fields are 0; age matrix is 0; count=0.
  - enq_ready=0 and deq_valid=0 while reset is high.
  - Reset mid-operation discards all contents immediately.
- Outputs:
  - enq_ready = (count<DEPTH) && !flush && !reset. Depends on registered state only; no same-cycle credit from a dequeue.
  - deq_valid = some entry is ready && !flush. An entry is ready when valid=1 and &cond=1.
  - deq_data and deq_index are 0 when deq_valid=0.
  - All outputs are combinational from registered state; no input-to-output path except flush.
- Enqueue (enq_valid && enq_ready):
  - Writes the lowest-numbered invalid slot s.
  - Stored cond = enq_cond OR (mask of every wakeup port this cycle whose wk_index == enq_index). This is the same-cycle bypass.
  - The new entry becomes visible to select on the next cycle.
- Wakeup:
  - Each cycle, each valid entry ORs in wk_mask of every port k with wk_valid[k] and wk_index[k]==entry tag.
  - Multiple ports hitting one entry OR together; multiple entries with the same tag all update.
  - Condition bits are never cleared except by dequeue, flush or reset.
- Age:
  - older[i][j]=1 means i is older than j.
  - On enqueue to slot s: row s is cleared and older[j][s]=1 for all j!=s.
  - Select picks ready entry i such that no other ready entry j has older[j][i]=1. Result is one-hot; ties are impossible.
- Dequeue (deq_valid && deq_ready):
  - The selected entry is invalidated and its fields zeroed at the clock edge.
  - Zero-cycle latency from ready to offer: an entry woken at edge t is offered in cycle t+1.
- Simultaneous events:
  - Enqueue and dequeue in the same cycle: count is unchanged. The freed slot is not reused that cycle; allocation uses pre-edge validity.
  - Wakeup on the entry being dequeued: ignored.
- Flush:
  - Highest priority after reset. At the edge all entries are invalidated and count=0.
  - Same-cycle enqueue, dequeue and wakeup are ignored; enq_ready and deq_valid are forced 0 during flush.
- Boundaries:
  - count==DEPTH: enq_ready=0; enq_valid is ignored with no state change.
  - count==0: deq_valid=0.
  - count never over- or underflows.

Test Plan (DEPTH=4, COND_WIDTH=2):
- Reset, then enqueue tags 1,2,3 with cond=2'b11 and deq_ready=1 → deq_index sequence 1,2,3 in oldest-first order; count returns to 0.
- Enqueue tag 5 cond=00, then tag 6 cond=11 → tag 6 is dequeued first. Wakeup port0 idx5 mask 01, then port1 idx5 mask 10 → tag 5 is offered the cycle after the second wakeup.
- Enqueue tag 7 cond=01 with wk_valid[0]=1, wk_index=7, wk_mask=10 in the same cycle → deq_valid=1 on the next cycle with deq_index=7.
- Fill 4 entries with cond=00 → enq_ready=0, count=4; a 5th enq_valid leaves count=4. Then enqueue and dequeue in one cycle at count=3 → count stays 3.
- Hold 3 valid entries, assert flush together with enq_valid and deq_ready → next cycle count=0 and deq_valid=0; the enqueued entry is absent.
- Assert reset mid-stream with 2 ready entries and deq_ready=0 → outputs go to 0 immediately; after reset release, enq_ready=1 and count=0.
